bcd_convert_arbiter: RTL and testbench



---
 rtl/bcd_convert_arbiter_pkg.sv | 29 ++
 rtl/bcd_convert_arbiter_if.sv | 26 ++
 rtl/bcd_convert_arbiter_digit_adj.sv | 11 +
 rtl/bcd_convert_arbiter.sv | 107 ++++++++++
 tb/tb_bcd_convert_arbiter.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/bcd_convert_arbiter_pkg.sv
// Shared types and helpers for the two-requester double-dabble BCD converter.
package bcd_pkg;

  localparam int BCD_DIGIT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Decimal digits needed to print the largest WIDTH-bit unsigned value.
  function automatic int min_digits(input int width);
    logic [127:0] maxv;
    logic [127:0] pow10;
    int           d;
    maxv  = (128'd1 << width) - 128'd1;
    pow10 = 128'd10;
    d     = 1;
    for (int i = 0; i < 40; i++) begin
      if (pow10 <= maxv) begin
        pow10 = pow10 * 128'd10;
        d     = d + 1;
      end
    end
    return d;
  endfunction

endpackage

// File: rtl/bcd_convert_arbiter_if.sv
// Request/result bundle between the two value sources and the shared BCD engine.
interface bcd_convert_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
);
  import bcd_pkg::*;

  logic [1:0]                    req;
  logic [WIDTH-1:0]              bin0;
  logic [WIDTH-1:0]              bin1;
  logic                          busy;
  logic                          gnt_id;
  logic                          done;
  logic [BCD_DIGIT_W*DIGITS-1:0] bcd;

  modport master (
    output req, bin0, bin1,
    input  busy, gnt_id, done, bcd
  );

  modport slave (
    input  req, bin0, bin1,
    output busy, gnt_id, done, bcd
  );

endinterface

// File: rtl/bcd_convert_arbiter_digit_adj.sv
// One double-dabble correction cell: a BCD digit of 5 or more gets 3 added.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [BCD_DIGIT_W-1:0] i_digit,
  output logic [BCD_DIGIT_W-1:0] o_digit
);

  assign o_digit = (i_digit >= BCD_DIGIT_W'(5)) ? (i_digit + BCD_DIGIT_W'(3)) : i_digit;

endmodule

// File: rtl/bcd_convert_arbiter.sv
// Round-robin shared binary-to-BCD engine: one bit per clock, result and
// winner id published together on a single-cycle done pulse.
module bcd_convert_arbiter
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DIGITS = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  bcd_convert_arbiter_if.slave bus
);

  localparam int BCD_W = BCD_DIGIT_W * DIGITS;
  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  generate
    if (DIGITS < min_digits(WIDTH)) begin : g_digits_check
      $error("bcd_convert_arbiter: DIGITS too small for WIDTH");
    end
  endgenerate

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [BCD_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ptr;
  logic             r_cur;
  logic             r_busy;
  logic             r_gnt_id;
  logic             r_done;
  logic [BCD_W-1:0] r_bcd;

  logic [BCD_W-1:0] w_adj;
  logic [BCD_W-1:0] w_next_acc;
  logic             w_winner;

  generate
    for (genvar d = 0; d < DIGITS; d++) begin : g_adj
      bcd_digit_adj u_adj (
        .i_digit (r_acc[d*BCD_DIGIT_W +: BCD_DIGIT_W]),
        .o_digit (w_adj[d*BCD_DIGIT_W +: BCD_DIGIT_W])
      );
    end
  endgenerate

  // Pointer only matters on a tie; a lone requester always wins.
  assign w_winner   = (bus.req == 2'b11) ? r_ptr : bus.req[1];
  assign w_next_acc = {w_adj[BCD_W-2:0], r_shreg[WIDTH-1]};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_shreg  <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_ptr    <= 1'b0;
      r_cur    <= 1'b0;
      r_busy   <= 1'b0;
      r_gnt_id <= 1'b0;
      r_done   <= 1'b0;
      r_bcd    <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (|bus.req) begin
            r_cur   <= w_winner;
            r_ptr   <= ~w_winner;
            r_shreg <= w_winner ? bus.bin1 : bus.bin0;
            r_acc   <= '0;
            r_cnt   <= CNT_LAST;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_acc   <= w_next_acc;
          r_shreg <= r_shreg << 1;
          if (r_cnt == '0) begin
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          // bcd and gnt_id only change here, so partial sums never leak out.
          r_bcd    <= r_acc;
          r_gnt_id <= r_cur;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.gnt_id = r_gnt_id;
  assign bus.done   = r_done;
  assign bus.bcd    = r_bcd;

endmodule

// File: tb/tb_bcd_convert_arbiter.sv
// Directed self-checking bench for bcd_convert_arbiter (WIDTH=32, DIGITS=10).
module tb_bcd_convert_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   edges;
  int   seen;

  bcd_convert_arbiter_if #(.WIDTH(32), .DIGITS(10)) bus ();

  bcd_convert_arbiter #(.WIDTH(32), .DIGITS(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Counts edges until done is seen, sampling 1ns after each rising edge.
  task automatic waitDone(input string tag, input int budget, output int count);
    count = 0;
    do begin
      @(posedge clk);
      #1;
      count++;
    end while (!bus.done && count < budget);
    checkOutput({tag, "_done"}, 64'(bus.done), 64'd1);
  endtask

  task automatic applyStimulus(input logic [1:0] r, input logic [31:0] b0, input logic [31:0] b1);
    bus.req  = r;
    bus.bin0 = b0;
    bus.bin1 = b1;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    applyStimulus(2'b11, 32'd12345678, 32'd90);

    repeat (3) begin
      @(posedge clk);
      #1;
      checkOutput("rst_busy", 64'(bus.busy), 64'd0);
      checkOutput("rst_done", 64'(bus.done), 64'd0);
      checkOutput("rst_bcd",  64'(bus.bcd),  64'd0);
    end

    // Both asking at reset release: requester 0 first, then requester 1.
    reset = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("grant_busy", 64'(bus.busy), 64'd1);
    waitDone("tie0", 60, edges);
    checkOutput("tie0_latency", 64'(edges), 64'd33);
    checkOutput("tie0_gnt", 64'(bus.gnt_id), 64'd0);
    checkOutput("tie0_bcd", 64'(bus.bcd), 64'h00_1234_5678);
    bus.req = 2'b10;
    waitDone("tie1", 60, edges);
    checkOutput("tie1_spacing", 64'(edges), 64'd34);
    checkOutput("tie1_gnt", 64'(bus.gnt_id), 64'd1);
    checkOutput("tie1_bcd", 64'(bus.bcd), 64'h00_0000_0090);
    bus.req = 2'b00;
    @(posedge clk);
    #1;
    checkOutput("done_pulse", 64'(bus.done), 64'd0);
    checkOutput("idle_busy", 64'(bus.busy), 64'd0);

    // Fairness with both requests held high.
    applyStimulus(2'b11, 32'd3, 32'd4);
    for (int k = 0; k < 4; k++) begin
      waitDone($sformatf("fair%0d", k), 60, edges);
      checkOutput($sformatf("fair%0d_gnt", k), 64'(bus.gnt_id), 64'(k % 2));
      checkOutput($sformatf("fair%0d_bcd", k), 64'(bus.bcd), (k % 2 == 0) ? 64'd3 : 64'd4);
    end
    bus.req = 2'b00;

    // Maximum value from requester 0 alone.
    @(posedge clk);
    #1;
    applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd0);
    @(posedge clk);
    #1;
    waitDone("max", 60, edges);
    checkOutput("max_latency", 64'(edges), 64'd33);
    checkOutput("max_gnt", 64'(bus.gnt_id), 64'd0);
    checkOutput("max_bcd", 64'(bus.bcd), 64'h42_9496_7295);
    bus.req = 2'b00;

    // Reset during SHIFT abandons the conversion.
    @(posedge clk);
    #1;
    applyStimulus(2'b01, 32'd77, 32'd0);
    @(posedge clk);
    #1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midshift_bcd_hold", 64'(bus.bcd), 64'h42_9496_7295);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset   = 1'b0;
    bus.req = 2'b00;
    checkOutput("abort_busy", 64'(bus.busy), 64'd0);
    checkOutput("abort_bcd",  64'(bus.bcd),  64'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) seen++;
    end
    checkOutput("abort_no_done", 64'(seen), 64'd0);
    applyStimulus(2'b10, 32'd0, 32'd1);
    waitDone("after_abort", 60, edges);
    checkOutput("after_abort_gnt", 64'(bus.gnt_id), 64'd1);
    checkOutput("after_abort_bcd", 64'(bus.bcd), 64'h00_0000_0001);
    bus.req = 2'b00;

    // bin changes after the grant edge are ignored.
    @(posedge clk);
    #1;
    applyStimulus(2'b01, 32'd999, 32'd0);
    @(posedge clk);
    #1;
    bus.bin0 = 32'd5;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("stable_midshift_bcd", 64'(bus.bcd), 64'h00_0000_0001);
    waitDone("stable", 60, edges);
    checkOutput("stable_gnt", 64'(bus.gnt_id), 64'd0);
    checkOutput("stable_bcd", 64'(bus.bcd), 64'h00_0000_0999);
    bus.req = 2'b00;

    // Zero still takes the full conversion time.
    @(posedge clk);
    #1;
    applyStimulus(2'b01, 32'd0, 32'd0);
    @(posedge clk);
    #1;
    waitDone("zero", 60, edges);
    checkOutput("zero_latency", 64'(edges), 64'd33);
    checkOutput("zero_bcd", 64'(bus.bcd), 64'd0);
    bus.req = 2'b00;

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
